// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and byte-level round helpers for the
// iterative encrypt core; the S-box table is the forward half of the cipher pair.
package aes_pkg;

    localparam int BLOCK_W       = 128;
    localparam int NB            = 4;
    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0x00 at the MSBs; the decryption side keeps the inverse table.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] s, input int i);
        return s[BLOCK_W-1 - 8*i -: 8];
    endfunction

    function automatic logic [BLOCK_W-1:0] sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[BLOCK_W-1 - 8*(row + 4*c) -: 8] = get_byte(s, row + 4*((c + row) % NB));
            end
        end
        return r;
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = get_byte(s, 4*c);
            a1 = get_byte(s, 4*c + 1);
            a2 = get_byte(s, 4*c + 2);
            a3 = get_byte(s, 4*c + 3);
            r[BLOCK_W-1 - 32*c -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns and
// AddRoundKey, with MixColumns bypassed when i_final is set.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_round_key,
    input  logic               i_final,
    output logic [BLOCK_W-1:0] o_state
);

    logic [BLOCK_W-1:0] w_sub;
    logic [BLOCK_W-1:0] w_shift;
    logic [BLOCK_W-1:0] w_mix;

    assign w_sub   = sub_bytes(i_state);
    assign w_shift = shift_rows(w_sub);
    assign w_mix   = mix_columns(w_shift);
    assign o_state = (i_final ? w_shift : w_mix) ^ i_round_key;

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryptor, one round per clock. Build option
// AES_ENC_KEY_LATCH_EN captures full_key at start so the caller may change it while busy.
module aes_encrypt_core
    import aes_pkg::*;
#(
    parameter  int MAX_ROUND = 10,
    localparam int KEY_W     = 128 * (MAX_ROUND + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [127:0]       in,
    input  logic [KEY_W-1:0]   full_key,
    output logic               busy,
    output logic               out_valid,
    output logic [127:0]       out
);

    if (MAX_ROUND != AES128_ROUNDS && MAX_ROUND != AES192_ROUNDS &&
        MAX_ROUND != AES256_ROUNDS) begin : g_bad_max_round
        $error("aes_encrypt_core: MAX_ROUND must be 10, 12 or 14");
    end

    localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUND);

    // Handshake: start is taken on any edge where the FSM is IDLE or DONE (ignored
    // in RUN); busy is high for the rounds; out_valid with out holds until the next
    // accepted start, and drops on that same edge.
    aes_state_e           r_fsm;
    logic [3:0]           r_round;
    logic [BLOCK_W-1:0]   r_state;
    logic [BLOCK_W-1:0]   r_out;
    logic                 r_busy;
    logic                 r_out_valid;

    logic [KEY_W-1:0]     w_sched;
    logic [BLOCK_W-1:0]   w_round_key;
    logic                 w_final;
    logic [BLOCK_W-1:0]   w_next_state;
    logic                 w_accept;

    assign w_accept = start && (r_fsm == IDLE || r_fsm == DONE);

`ifdef AES_ENC_KEY_LATCH_EN
    logic [KEY_W-1:0] r_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key <= '0;
        end else if (w_accept) begin
            r_key <= full_key;
        end
    end

    assign w_sched = r_key;
`else
    assign w_sched = full_key;
`endif

    assign w_round_key = w_sched[BLOCK_W*int'(r_round) +: BLOCK_W];
    assign w_final     = (r_round == LAST_ROUND);

    aes_enc_round u_round (
        .i_state     (r_state),
        .i_round_key (w_round_key),
        .i_final     (w_final),
        .o_state     (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_round     <= 4'd0;
            r_state     <= '0;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE, DONE: begin
                    if (start) begin
                        // Round 0 always uses the live key: a latched copy is not yet loaded.
                        r_state     <= in ^ full_key[BLOCK_W-1:0];
                        r_round     <= 4'd1;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_fsm       <= RUN;
                    end
                end
                RUN: begin
                    r_state <= w_next_state;
                    if (w_final) begin
                        r_out       <= w_next_state;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule
